mem_access: RTL and testbench

Memory-access stage of the five-stage RV32I pipeline. It sits directly downstream of the execute stage. It latches the EX/MEM bundle and performs loads and stores through a request/response data-memory port. It stalls the upstream pipeline until the memory responds, aligns and extends load data, and registers the result toward writeback.

---
 rtl/mem_access_if.sv | 17 +
 rtl/mem_access.sv | 182 ++++++++++++++++++
 tb/tb_mem_access.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Data-memory request/response port of the RV32I memory-access stage.
// The stage drives the request side (master); the memory drives rdata/resp (slave).
interface mem_access_if;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned MBE_W = 4;

   logic             read;
   logic             write;
   logic [XLEN-1:0]  addr;
   logic [MBE_W-1:0] mbe;
   logic [XLEN-1:0]  wdata;
   logic [XLEN-1:0]  rdata;
   logic             resp;

   modport master (output read, write, addr, mbe, wdata, input rdata, resp);
   modport slave  (input read, write, addr, mbe, wdata, output rdata, resp);
endinterface

// File: rtl/mem_access.sv
// Memory-access stage of the five-stage RV32I pipeline: latches the EX/MEM bundle,
// runs loads/stores over a request/response port, stalls upstream, registers toward WB.
module mem_access (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ex_valid,
   input  logic         ex_read,
   input  logic         ex_write,
   input  logic [2:0]   ex_funct3,
   input  logic [31:0]  ex_mar,
   input  logic [31:0]  ex_wdata,
   input  logic [4:0]   ex_rd,
   input  logic         ex_regwrite,
   input  logic [31:0]  ex_result,
   mem_access_if.master dmem,
   output logic         stall,
   output logic         wb_valid,
   output logic         wb_regwrite,
   output logic [4:0]   wb_rd,
   output logic [31:0]  wb_data,
   output logic         wb_misalign,
   output logic [31:0]  stall_count
);
   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned F3_W   = 3;
   localparam int unsigned MBE_W  = 4;
   localparam int unsigned HALF_W = 16;

   localparam logic [F3_W-1:0]  F3_BYTE  = 3'b000;
   localparam logic [F3_W-1:0]  F3_HALF  = 3'b001;
   localparam logic [F3_W-1:0]  F3_WORD  = 3'b010;
   localparam logic [F3_W-1:0]  F3_BYTEU = 3'b100;
   localparam logic [F3_W-1:0]  F3_HALFU = 3'b101;

   localparam logic [MBE_W-1:0] MBE_BYTE = 4'b0001;
   localparam logic [MBE_W-1:0] MBE_HALF = 4'b0011;
   localparam logic [MBE_W-1:0] MBE_WORD = 4'b1111;

   typedef struct packed {
      logic             valid;
      logic             read;
      logic             write;
      logic [F3_W-1:0]  funct3;
      logic [XLEN-1:0]  mar;
      logic [XLEN-1:0]  wdata;
      logic [REG_W-1:0] rd;
      logic             regwrite;
      logic [XLEN-1:0]  result;
   } m_reg_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   m_reg_t            m_q;
   m_reg_t            m_d;
   state_t            state_q;
   state_t            state_d;

   logic              is_half;
   logic              is_word;
   logic              mem_ref;
   logic              misal;
   logic              mop;
   logic [MBE_W-1:0]  store_mbe;
   logic [HALF_W-1:0] lane;
   logic [XLEN-1:0]   load_data;

   // EX bundle packed into the M register payload
   always_comb begin
      m_d          = '0;
      m_d.valid    = ex_valid;
      m_d.read     = ex_read;
      m_d.write    = ex_write;
      m_d.funct3   = ex_funct3;
      m_d.mar      = ex_mar;
      m_d.wdata    = ex_wdata;
      m_d.rd       = ex_rd;
      m_d.regwrite = ex_regwrite;
      m_d.result   = ex_result;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q <= '0;
      end else if (!stall) begin
         m_q <= m_d;
      end
   end

   // Misaligned halfword/word accesses are suppressed and never reach memory
   always_comb begin
      is_half = (m_q.funct3 == F3_HALF) || (m_q.funct3 == F3_HALFU);
      is_word = (m_q.funct3 == F3_WORD);
      mem_ref = m_q.valid & (m_q.read | m_q.write);
      misal   = mem_ref & ((is_half & m_q.mar[0]) | (is_word & (m_q.mar[1:0] != 2'b00)));
      mop     = mem_ref & ~misal;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (mop && !dmem.resp) state_d = ST_WAIT;
         ST_WAIT: if (dmem.resp)         state_d = ST_IDLE;
         default:                        state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      store_mbe = MBE_WORD;
      case (m_q.funct3[1:0])
         2'b00:   store_mbe = MBE_W'(MBE_BYTE << m_q.mar[1:0]);
         2'b01:   store_mbe = MBE_W'(MBE_HALF << m_q.mar[1:0]);
         default: store_mbe = MBE_WORD;
      endcase
   end

   // Request stays up, with stable payload, through the response cycle
   always_comb begin
      stall      = mop & ~dmem.resp;
      dmem.read  = mop & m_q.read;
      dmem.write = mop & m_q.write;
      dmem.addr  = {m_q.mar[XLEN-1:2], 2'b00};
      dmem.wdata = m_q.wdata;
      dmem.mbe   = '0;
      if (mop && m_q.write) begin
         dmem.mbe = store_mbe;
      end
   end

   always_comb begin
      lane      = HALF_W'(dmem.rdata >> {m_q.mar[1:0], 3'b000});
      load_data = dmem.rdata;
      case (m_q.funct3)
         F3_BYTE:  load_data = {{(XLEN-8){lane[7]}}, lane[7:0]};
         F3_BYTEU: load_data = {{(XLEN-8){1'b0}}, lane[7:0]};
         F3_HALF:  load_data = {{(XLEN-HALF_W){lane[HALF_W-1]}}, lane};
         F3_HALFU: load_data = {{(XLEN-HALF_W){1'b0}}, lane};
         default:  load_data = dmem.rdata;
      endcase
   end

   // W register: bubble while stalled, rd/data hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid    <= 1'b0;
         wb_regwrite <= 1'b0;
         wb_rd       <= '0;
         wb_data     <= '0;
         wb_misalign <= 1'b0;
      end else if (stall) begin
         wb_valid    <= 1'b0;
         wb_regwrite <= 1'b0;
         wb_misalign <= 1'b0;
      end else begin
         wb_valid    <= m_q.valid;
         wb_regwrite <= m_q.valid & m_q.regwrite & ~misal;
         wb_rd       <= m_q.rd;
         wb_data     <= m_q.read ? load_data : m_q.result;
         wb_misalign <= misal;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count <= '0;
      end else if (stall && (stall_count != '1)) begin
         stall_count <= stall_count + XLEN'(1);
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: byte-level reference model, latency-programmable memory
// responder, per-cycle WB compare, and directed literal checks.
module tb_mem_access;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_read, ex_write, ex_regwrite;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_mar, ex_wdata, ex_result;
   logic [4:0]  ex_rd;
   logic        stall, wb_valid, wb_regwrite, wb_misalign;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data, stall_count;

   mem_access_if dmem ();

   mem_access dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_read(ex_read), .ex_write(ex_write),
      .ex_funct3(ex_funct3), .ex_mar(ex_mar), .ex_wdata(ex_wdata),
      .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_result(ex_result),
      .dmem(dmem), .stall(stall),
      .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
      .wb_data(wb_data), .wb_misalign(wb_misalign), .stall_count(stall_count)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        regwrite;
      logic        misal;
      logic        chk_data;
   } wb_exp_t;

   typedef struct {
      int          lat;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  mbe;
      logic [31:0] wdata;
   } req_exp_t;

   wb_exp_t     wb_q[$];
   req_exp_t    req_q[$];
   logic [7:0]  ref_mem [0:1023];
   logic [31:0] mem     [0:255];
   int          checks = 0;
   int          failures = 0;
   int          exp_stall = 0;
   int          exp_reqs = 0;
   int          seen_reqs = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%08h required=0x%08h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      #2;
   endtask

   task automatic wait_free();
      for (int t = 0; t < 100 && stall; t++) begin
         @(negedge clk);
         #2;
      end
      if (stall) begin
         checks++;
         failures++;
         $display("FAIL wait_free_timeout: stall stuck at 1 @%0t", $time);
      end
      step();
   endtask

   // Model derives the expected WB/request from byte-addressed memory, then presents the op
   task automatic issue(input logic v, input logic rd_op, input logic wr_op, input logic [2:0] f3,
                        input logic [31:0] mar, input logic [31:0] wd, input logic [4:0] rd,
                        input logic rw, input logic [31:0] res, input int lat);
      int          size;
      logic        mis;
      logic [31:0] ld;
      wb_exp_t     w;
      req_exp_t    r;
      size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      mis  = v && (rd_op || wr_op) && ((mar % 32'(size)) != 0);
      if (v) begin
         ld = '0;
         for (int k = 0; k < size; k++) ld[8*k +: 8] = ref_mem[10'(mar + 32'(k))];
         if (size == 1) ld = f3[2] ? {24'b0, ld[7:0]} : {{24{ld[7]}}, ld[7:0]};
         if (size == 2) ld = f3[2] ? {16'b0, ld[15:0]} : {{16{ld[15]}}, ld[15:0]};
         w.rd = rd; w.data = rd_op ? ld : res; w.regwrite = rw && !mis;
         w.misal = mis; w.chk_data = !(rd_op && mis);
         wb_q.push_back(w);
         if ((rd_op || wr_op) && !mis) begin
            r.lat = lat; r.rd = rd_op; r.wr = wr_op; r.addr = mar & ~32'd3;
            r.mbe = '0; r.wdata = wd;
            if (wr_op) begin
               for (int k = 0; k < size; k++) begin
                  r.mbe[(mar + 32'(k)) % 4] = 1'b1;
                  ref_mem[10'(mar + 32'(k))] = wd[8*((mar + 32'(k)) % 4) +: 8];
               end
            end
            req_q.push_back(r);
            exp_stall += lat;
            exp_reqs++;
         end
      end
      ex_valid = v; ex_read = rd_op; ex_write = wr_op; ex_funct3 = f3; ex_mar = mar;
      ex_wdata = wd; ex_rd = rd; ex_regwrite = rw; ex_result = res;
      for (int t = 0; stall; t++) begin
         if (t >= 100) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout: stall stuck at 1 @%0t", $time);
            break;
         end
         @(negedge clk);
         #2;
      end
      @(posedge clk);
      @(negedge clk);
      #2;
      ex_valid = 0; ex_read = 0; ex_write = 0; ex_regwrite = 0;
   endtask

   // Memory responder: answers each request after its programmed latency
   initial begin
      logic        busy;
      logic        req;
      int          cnt;
      req_exp_t    cur;
      logic [31:0] cap_addr, cap_wdata;
      logic [3:0]  cap_mbe;
      logic        cap_rd, cap_wr;
      busy = 0; cnt = 0;
      cur.lat = 0; cur.rd = 0; cur.wr = 0; cur.addr = 0; cur.mbe = 0; cur.wdata = 0;
      cap_addr = 0; cap_wdata = 0; cap_mbe = 0; cap_rd = 0; cap_wr = 0;
      dmem.resp = 1'b0;
      dmem.rdata = '0;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            busy = 0;
            dmem.resp = 1'b0;
         end else begin
            req = dmem.read || dmem.write;
            if (req) begin
               if (!busy) begin
                  cnt = 0;
                  if (req_q.size() == 0) begin
                     checks++;
                     failures++;
                     $display("FAIL unexpected_request: addr=0x%08h read=%0b write=%0b", dmem.addr, dmem.read, dmem.write);
                     cur.lat = 0; cur.rd = dmem.read; cur.wr = dmem.write; cur.addr = dmem.addr;
                     cur.mbe = dmem.mbe; cur.wdata = dmem.wdata;
                  end else begin
                     cur = req_q.pop_front();
                  end
                  check("req_read", 32'(dmem.read), 32'(cur.rd));
                  check("req_write", 32'(dmem.write), 32'(cur.wr));
                  check("req_addr", dmem.addr, cur.addr);
                  check("req_mbe", 32'(dmem.mbe), 32'(cur.mbe));
                  if (cur.wr) check("req_wdata", dmem.wdata, cur.wdata);
                  cap_addr = dmem.addr; cap_wdata = dmem.wdata; cap_mbe = dmem.mbe;
                  cap_rd = dmem.read; cap_wr = dmem.write;
               end else begin
                  cnt++;
                  check("hold_addr", dmem.addr, cap_addr);
                  check("hold_mbe", 32'(dmem.mbe), 32'(cap_mbe));
                  check("hold_read", 32'(dmem.read), 32'(cap_rd));
                  check("hold_write", 32'(dmem.write), 32'(cap_wr));
                  if (cap_wr) check("hold_wdata", dmem.wdata, cap_wdata);
               end
               if (cnt >= cur.lat) begin
                  dmem.resp = 1'b1;
                  busy = 0;
                  seen_reqs++;
                  if (dmem.write) begin
                     for (int k = 0; k < 4; k++)
                        if (dmem.mbe[k]) mem[dmem.addr[9:2]][8*k +: 8] = dmem.wdata[8*k +: 8];
                  end else begin
                     dmem.rdata = mem[dmem.addr[9:2]];
                  end
               end else begin
                  dmem.resp = 1'b0;
                  busy = 1;
               end
            end else begin
               check("req_dropped", 32'(busy), 32'd0);
               dmem.resp = 1'b0;
               busy = 0;
            end
            #1;
            check("stall", 32'(stall), 32'(req && !dmem.resp));
         end
      end
   end

   // WB compare against the model queue on every cycle out of reset
   initial begin
      wb_exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (rst_n === 1'b1) begin
            if (wb_valid === 1'b1) begin
               if (wb_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_wb: rd=%0d data=0x%08h", wb_rd, wb_data);
               end else begin
                  e = wb_q.pop_front();
                  check("wb_rd", 32'(wb_rd), 32'(e.rd));
                  check("wb_regwrite", 32'(wb_regwrite), 32'(e.regwrite));
                  check("wb_misalign", 32'(wb_misalign), 32'(e.misal));
                  if (e.chk_data) check("wb_data", wb_data, e.data);
               end
            end else begin
               check("bubble_regwrite", 32'(wb_regwrite), 32'd0);
               check("bubble_misalign", 32'(wb_misalign), 32'd0);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      ex_valid = 0; ex_read = 0; ex_write = 0; ex_funct3 = 0; ex_mar = 0;
      ex_wdata = 0; ex_rd = 0; ex_regwrite = 0; ex_result = 0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i * 7 + 3);
      ref_mem[32'h100] = 8'h00; ref_mem[32'h101] = 8'hFF;
      ref_mem[32'h102] = 8'hFF; ref_mem[32'h103] = 8'h80;
      for (int i = 0; i < 256; i++)
         mem[i] = {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};

      repeat (2) @(negedge clk);
      #2;
      check("rst_wb_valid", 32'(wb_valid), 32'd0);
      check("rst_wb_data", wb_data, 32'd0);
      check("rst_stall_count", stall_count, 32'd0);
      check("rst_dmem_read", 32'(dmem.read), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_mbe", 32'(dmem.mbe), 32'd0);
      rst_n = 1'b1;
      step();

      // ALU op: two edges to W
      issue(1, 0, 0, 3'b000, 32'h0, 32'h0, 5'd5, 1, 32'h1234, 0);
      check("alu_stall", 32'(stall), 32'd0);
      step();
      check("alu_wb_valid", 32'(wb_valid), 32'd1);
      check("alu_wb_rd", 32'(wb_rd), 32'd5);
      check("alu_wb_data", wb_data, 32'h1234);

      // lb / lbu at 0x103 with three wait cycles
      issue(1, 1, 0, 3'b000, 32'h103, 32'h0, 5'd6, 1, 32'h0, 3);
      check("lb_addr", dmem.addr, 32'h100);
      check("lb_read", 32'(dmem.read), 32'd1);
      wait_free();
      check("lb_data", wb_data, 32'hFFFF_FF80);
      check("lb_stall_count", stall_count, 32'd3);
      issue(1, 1, 0, 3'b100, 32'h103, 32'h0, 5'd7, 1, 32'h0, 3);
      wait_free();
      check("lbu_data", wb_data, 32'h0000_0080);
      check("lbu_stall_count", stall_count, 32'd6);

      // sh at 0x202, held across stall
      issue(1, 0, 1, 3'b001, 32'h202, 32'hBEEF_0000, 5'd0, 0, 32'hAA, 2);
      check("sh_write", 32'(dmem.write), 32'd1);
      check("sh_mbe", 32'(dmem.mbe), 32'b1100);
      check("sh_wdata", dmem.wdata, 32'hBEEF_0000);
      step();
      check("sh_write_held", 32'(dmem.write), 32'd1);
      check("sh_mbe_held", 32'(dmem.mbe), 32'b1100);
      wait_free();
      check("sh_wb_valid", 32'(wb_valid), 32'd1);
      check("sh_wb_regwrite", 32'(wb_regwrite), 32'd0);

      // misaligned lw
      issue(1, 1, 0, 3'b010, 32'h6, 32'h0, 5'd8, 1, 32'h0, 0);
      check("mis_read", 32'(dmem.read), 32'd0);
      check("mis_stall", 32'(stall), 32'd0);
      step();
      check("mis_wb_misalign", 32'(wb_misalign), 32'd1);
      check("mis_wb_regwrite", 32'(wb_regwrite), 32'd0);

      // halfword reads of the stored data
      issue(1, 1, 0, 3'b101, 32'h202, 32'h0, 5'd9, 1, 32'h0, 1);
      wait_free();
      check("lhu_data", wb_data, 32'h0000_BEEF);
      issue(1, 1, 0, 3'b001, 32'h202, 32'h0, 5'd10, 1, 32'h0, 0);
      step();
      check("lh_data", wb_data, 32'hFFFF_BEEF);

      // back-to-back lw with same-cycle response
      issue(1, 1, 0, 3'b010, 32'h200, 32'h0, 5'd11, 1, 32'h0, 0);
      issue(1, 1, 0, 3'b010, 32'h100, 32'h0, 5'd12, 1, 32'h0, 0);
      check("b2b_first_valid", 32'(wb_valid), 32'd1);
      check("b2b_first_data", wb_data, 32'hBEEF_0A03);
      check("b2b_stall", 32'(stall), 32'd0);
      step();
      check("b2b_second_valid", 32'(wb_valid), 32'd1);
      check("b2b_second_data", wb_data, 32'h80FF_FF00);
      check("b2b_stall_count", stall_count, 32'd9);

      // sb, sw, suppressed misaligned sw, then read back
      issue(1, 0, 1, 3'b000, 32'h301, 32'h0000_AB00, 5'd0, 0, 32'h1, 1);
      issue(1, 0, 1, 3'b010, 32'h304, 32'h1234_5678, 5'd0, 0, 32'h2, 0);
      issue(1, 0, 1, 3'b010, 32'h302, 32'hDEAD_BEEF, 5'd0, 0, 32'h3, 0);
      check("mis_sw_write", 32'(dmem.write), 32'd0);
      issue(1, 1, 0, 3'b010, 32'h300, 32'h0, 5'd13, 1, 32'h0, 2);
      wait_free();
      check("lw_after_sb", wb_data, 32'h1811_AB03);
      issue(1, 1, 0, 3'b010, 32'h304, 32'h0, 5'd14, 1, 32'h0, 0);
      step();
      check("lw_after_sw", wb_data, 32'h1234_5678);

      // reset during WAIT abandons the request
      issue(1, 1, 0, 3'b010, 32'h10, 32'h0, 5'd15, 1, 32'h0, 10);
      @(negedge clk);
      #2;
      check("wait_stall", 32'(stall), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rstw_read", 32'(dmem.read), 32'd0);
      check("rstw_stall", 32'(stall), 32'd0);
      check("rstw_wb_valid", 32'(wb_valid), 32'd0);
      check("rstw_stall_count", stall_count, 32'd0);
      wb_q.delete();
      req_q.delete();
      exp_stall = 0;
      exp_reqs = 0;
      seen_reqs = 0;
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("post_rst_read", 32'(dmem.read), 32'd0);
         check("post_rst_stall", 32'(stall), 32'd0);
         check("post_rst_wb_valid", 32'(wb_valid), 32'd0);
      end

      issue(1, 1, 0, 3'b010, 32'h100, 32'h0, 5'd16, 1, 32'h0, 1);
      wait_free();
      check("recover_data", wb_data, 32'h80FF_FF00);
      step();
      step();

      check("wb_queue_empty", 32'(wb_q.size()), 32'd0);
      check("req_queue_empty", 32'(req_q.size()), 32'd0);
      check("req_count", 32'(seen_reqs), 32'(exp_reqs));
      check("stall_count_total", stall_count, 32'(exp_stall));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
